// File: rtl/pipe_regs.sv
// pipe_regs: pipeline register bank for the five-stage Y86-64 core.
// Holds the F, D, E, M and W registers, applying stall (hold) and bubble
// (NOP injection) controls from hazard logic, plus saturating performance
// counters and a sticky flag for contradictory D-stage controls.
module pipe_regs #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             F_stall,
  input  logic             D_stall,
  input  logic             D_bubble,
  input  logic             E_bubble,
  input  logic             M_bubble,
  input  logic             W_stall,
  input  logic [63:0]      f_predPC,
  output logic [63:0]      F_predPC,
  input  logic [2:0]       f_stat,
  input  logic [3:0]       f_icode,
  input  logic [3:0]       f_ifun,
  input  logic [3:0]       f_rA,
  input  logic [3:0]       f_rB,
  input  logic [63:0]      f_valC,
  input  logic [63:0]      f_valP,
  output logic [2:0]       D_stat,
  output logic [3:0]       D_icode,
  output logic [3:0]       D_ifun,
  output logic [3:0]       D_rA,
  output logic [3:0]       D_rB,
  output logic [63:0]      D_valC,
  output logic [63:0]      D_valP,
  input  logic [2:0]       d_stat,
  input  logic [3:0]       d_icode,
  input  logic [3:0]       d_ifun,
  input  logic [63:0]      d_valC,
  input  logic [63:0]      d_valA,
  input  logic [63:0]      d_valB,
  input  logic [3:0]       d_dstE,
  input  logic [3:0]       d_dstM,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  output logic [2:0]       E_stat,
  output logic [3:0]       E_icode,
  output logic [3:0]       E_ifun,
  output logic [63:0]      E_valC,
  output logic [63:0]      E_valA,
  output logic [63:0]      E_valB,
  output logic [3:0]       E_dstE,
  output logic [3:0]       E_dstM,
  output logic [3:0]       E_srcA,
  output logic [3:0]       E_srcB,
  input  logic [2:0]       e_stat,
  input  logic [3:0]       e_icode,
  input  logic             e_Cnd,
  input  logic [63:0]      e_valE,
  input  logic [63:0]      e_valA,
  input  logic [3:0]       e_dstE,
  input  logic [3:0]       e_dstM,
  output logic [2:0]       M_stat,
  output logic [3:0]       M_icode,
  output logic             M_Cnd,
  output logic [63:0]      M_valE,
  output logic [63:0]      M_valA,
  output logic [3:0]       M_dstE,
  output logic [3:0]       M_dstM,
  input  logic [2:0]       m_stat,
  input  logic [3:0]       m_icode,
  input  logic [63:0]      m_valE,
  input  logic [63:0]      m_valM,
  input  logic [3:0]       m_dstE,
  input  logic [3:0]       m_dstM,
  output logic [2:0]       W_stat,
  output logic [3:0]       W_icode,
  output logic [63:0]      W_valE,
  output logic [63:0]      W_valM,
  output logic [3:0]       W_dstE,
  output logic [3:0]       W_dstM,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             ctrl_err
);

  localparam logic [2:0]       STAT_AOK = 3'd1;
  localparam logic [3:0]       I_NOP    = 4'd1;
  localparam logic [3:0]       R_NONE   = 4'hF;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic any_bubble;
  logic retire_now;

  assign any_bubble = D_bubble | E_bubble | M_bubble;
  assign retire_now = !W_stall && (W_stat == STAT_AOK) && (W_icode != I_NOP);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // F register: predicted PC, held while fetch is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      F_predPC <= '0;
    end else if (!F_stall) begin
      F_predPC <= f_predPC;
    end
  end

  // D register: stall has priority over bubble so a contradictory pair holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      D_stat  <= STAT_AOK;
      D_icode <= I_NOP;
      D_ifun  <= '0;
      D_rA    <= R_NONE;
      D_rB    <= R_NONE;
      D_valC  <= '0;
      D_valP  <= '0;
    end else if (D_stall) begin
      D_stat  <= D_stat;
    end else if (D_bubble) begin
      D_stat  <= STAT_AOK;
      D_icode <= I_NOP;
      D_ifun  <= '0;
      D_rA    <= R_NONE;
      D_rB    <= R_NONE;
      D_valC  <= '0;
      D_valP  <= '0;
    end else begin
      D_stat  <= f_stat;
      D_icode <= f_icode;
      D_ifun  <= f_ifun;
      D_rA    <= f_rA;
      D_rB    <= f_rB;
      D_valC  <= f_valC;
      D_valP  <= f_valP;
    end
  end

  // E register: loads decode results or a NOP bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || E_bubble) begin
      if (!rst_n || E_bubble) begin
        E_stat  <= STAT_AOK;
        E_icode <= I_NOP;
        E_ifun  <= '0;
        E_valC  <= '0;
        E_valA  <= '0;
        E_valB  <= '0;
        E_dstE  <= R_NONE;
        E_dstM  <= R_NONE;
        E_srcA  <= R_NONE;
        E_srcB  <= R_NONE;
      end
    end else begin
      E_stat  <= d_stat;
      E_icode <= d_icode;
      E_ifun  <= d_ifun;
      E_valC  <= d_valC;
      E_valA  <= d_valA;
      E_valB  <= d_valB;
      E_dstE  <= d_dstE;
      E_dstM  <= d_dstM;
      E_srcA  <= d_srcA;
      E_srcB  <= d_srcB;
    end
  end

  // M register: loads execute results or a NOP bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      M_stat  <= STAT_AOK;
      M_icode <= I_NOP;
      M_Cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= R_NONE;
      M_dstM  <= R_NONE;
    end else if (M_bubble) begin
      M_stat  <= STAT_AOK;
      M_icode <= I_NOP;
      M_Cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= R_NONE;
      M_dstM  <= R_NONE;
    end else begin
      M_stat  <= e_stat;
      M_icode <= e_icode;
      M_Cnd   <= e_Cnd;
      M_valE  <= e_valE;
      M_valA  <= e_valA;
      M_dstE  <= e_dstE;
      M_dstM  <= e_dstM;
    end
  end

  // W register: loads memory results unless writeback is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      W_stat  <= STAT_AOK;
      W_icode <= I_NOP;
      W_valE  <= '0;
      W_valM  <= '0;
      W_dstE  <= R_NONE;
      W_dstM  <= R_NONE;
    end else if (!W_stall) begin
      W_stat  <= m_stat;
      W_icode <= m_icode;
      W_valE  <= m_valE;
      W_valM  <= m_valM;
      W_dstE  <= m_dstE;
      W_dstM  <= m_dstM;
    end
  end

  // Saturating performance counters; retire counts the instruction now in W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt  <= '0;
      stall_cnt  <= '0;
      bubble_cnt <= '0;
      retire_cnt <= '0;
    end else begin
      cycle_cnt <= sat_inc(cycle_cnt);
      if (F_stall)    stall_cnt  <= sat_inc(stall_cnt);
      if (any_bubble) bubble_cnt <= sat_inc(bubble_cnt);
      if (retire_now) retire_cnt <= sat_inc(retire_cnt);
    end
  end

  // Sticky error flag for simultaneous D stall and bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_err <= 1'b0;
    end else if (D_stall && D_bubble) begin
      ctrl_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_regs.sv
// tb_pipe_regs: scoreboard bench for pipe_regs with a narrow counter width
// so saturation is reachable within a short run.
module tb_pipe_regs;

  localparam int CW = 4;

  logic clk, rst_n;
  logic F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall;
  logic [63:0] f_predPC, F_predPC;
  logic [2:0] f_stat; logic [3:0] f_icode, f_ifun, f_rA, f_rB; logic [63:0] f_valC, f_valP;
  logic [2:0] D_stat; logic [3:0] D_icode, D_ifun, D_rA, D_rB; logic [63:0] D_valC, D_valP;
  logic [2:0] d_stat; logic [3:0] d_icode, d_ifun; logic [63:0] d_valC, d_valA, d_valB;
  logic [3:0] d_dstE, d_dstM, d_srcA, d_srcB;
  logic [2:0] E_stat; logic [3:0] E_icode, E_ifun; logic [63:0] E_valC, E_valA, E_valB;
  logic [3:0] E_dstE, E_dstM, E_srcA, E_srcB;
  logic [2:0] e_stat; logic [3:0] e_icode; logic e_Cnd; logic [63:0] e_valE, e_valA; logic [3:0] e_dstE, e_dstM;
  logic [2:0] M_stat; logic [3:0] M_icode; logic M_Cnd; logic [63:0] M_valE, M_valA; logic [3:0] M_dstE, M_dstM;
  logic [2:0] m_stat; logic [3:0] m_icode; logic [63:0] m_valE, m_valM; logic [3:0] m_dstE, m_dstM;
  logic [2:0] W_stat; logic [3:0] W_icode; logic [63:0] W_valE, W_valM; logic [3:0] W_dstE, W_dstM;
  logic [CW-1:0] cycle_cnt, stall_cnt, bubble_cnt, retire_cnt;
  logic ctrl_err;

  typedef struct {
    logic [63:0] F_predPC;
    logic [2:0] D_stat; logic [3:0] D_icode, D_ifun, D_rA, D_rB; logic [63:0] D_valC, D_valP;
    logic [2:0] E_stat; logic [3:0] E_icode, E_ifun; logic [63:0] E_valC, E_valA, E_valB;
    logic [3:0] E_dstE, E_dstM, E_srcA, E_srcB;
    logic [2:0] M_stat; logic [3:0] M_icode; logic M_Cnd; logic [63:0] M_valE, M_valA; logic [3:0] M_dstE, M_dstM;
    logic [2:0] W_stat; logic [3:0] W_icode; logic [63:0] W_valE, W_valM; logic [3:0] W_dstE, W_dstM;
    logic [CW-1:0] cyc, stl, bub, ret;
    logic err;
  } exp_t;

  exp_t mdl;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  pipe_regs #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
    .f_predPC(f_predPC), .F_predPC(F_predPC),
    .f_stat(f_stat), .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
    .f_valC(f_valC), .f_valP(f_valP),
    .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP),
    .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun), .d_valC(d_valC), .d_valA(d_valA),
    .d_valB(d_valB), .d_dstE(d_dstE), .d_dstM(d_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_valC(E_valC), .E_valA(E_valA),
    .E_valB(E_valB), .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB),
    .e_stat(e_stat), .e_icode(e_icode), .e_Cnd(e_Cnd), .e_valE(e_valE), .e_valA(e_valA),
    .e_dstE(e_dstE), .e_dstM(e_dstM),
    .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valE(M_valE), .M_valA(M_valA),
    .M_dstE(M_dstE), .M_dstM(M_dstM),
    .m_stat(m_stat), .m_icode(m_icode), .m_valE(m_valE), .m_valM(m_valM),
    .m_dstE(m_dstE), .m_dstM(m_dstM),
    .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
    .W_dstE(W_dstE), .W_dstM(W_dstM),
    .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
    .retire_cnt(retire_cnt), .ctrl_err(ctrl_err)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t nop_state();
    exp_t s;
    s.F_predPC = '0;
    s.D_stat = 3'd1; s.D_icode = 4'd1; s.D_ifun = 4'd0; s.D_rA = 4'hF; s.D_rB = 4'hF;
    s.D_valC = '0; s.D_valP = '0;
    s.E_stat = 3'd1; s.E_icode = 4'd1; s.E_ifun = 4'd0; s.E_valC = '0; s.E_valA = '0; s.E_valB = '0;
    s.E_dstE = 4'hF; s.E_dstM = 4'hF; s.E_srcA = 4'hF; s.E_srcB = 4'hF;
    s.M_stat = 3'd1; s.M_icode = 4'd1; s.M_Cnd = 1'b0; s.M_valE = '0; s.M_valA = '0;
    s.M_dstE = 4'hF; s.M_dstM = 4'hF;
    s.W_stat = 3'd1; s.W_icode = 4'd1; s.W_valE = '0; s.W_valM = '0; s.W_dstE = 4'hF; s.W_dstM = 4'hF;
    s.cyc = '0; s.stl = '0; s.bub = '0; s.ret = '0; s.err = 1'b0;
    return s;
  endfunction

  function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : CW'(v + 1);
  endfunction

  task automatic compareState(input exp_t e);
    checkOutput("F_predPC", F_predPC, e.F_predPC);
    checkOutput("D_stat", D_stat, e.D_stat);   checkOutput("D_icode", D_icode, e.D_icode);
    checkOutput("D_ifun", D_ifun, e.D_ifun);   checkOutput("D_rA", D_rA, e.D_rA);
    checkOutput("D_rB", D_rB, e.D_rB);         checkOutput("D_valC", D_valC, e.D_valC);
    checkOutput("D_valP", D_valP, e.D_valP);
    checkOutput("E_stat", E_stat, e.E_stat);   checkOutput("E_icode", E_icode, e.E_icode);
    checkOutput("E_ifun", E_ifun, e.E_ifun);   checkOutput("E_valC", E_valC, e.E_valC);
    checkOutput("E_valA", E_valA, e.E_valA);   checkOutput("E_valB", E_valB, e.E_valB);
    checkOutput("E_dstE", E_dstE, e.E_dstE);   checkOutput("E_dstM", E_dstM, e.E_dstM);
    checkOutput("E_srcA", E_srcA, e.E_srcA);   checkOutput("E_srcB", E_srcB, e.E_srcB);
    checkOutput("M_stat", M_stat, e.M_stat);   checkOutput("M_icode", M_icode, e.M_icode);
    checkOutput("M_Cnd", M_Cnd, e.M_Cnd);      checkOutput("M_valE", M_valE, e.M_valE);
    checkOutput("M_valA", M_valA, e.M_valA);   checkOutput("M_dstE", M_dstE, e.M_dstE);
    checkOutput("M_dstM", M_dstM, e.M_dstM);
    checkOutput("W_stat", W_stat, e.W_stat);   checkOutput("W_icode", W_icode, e.W_icode);
    checkOutput("W_valE", W_valE, e.W_valE);   checkOutput("W_valM", W_valM, e.W_valM);
    checkOutput("W_dstE", W_dstE, e.W_dstE);   checkOutput("W_dstM", W_dstM, e.W_dstM);
    checkOutput("cycle_cnt", cycle_cnt, e.cyc);   checkOutput("stall_cnt", stall_cnt, e.stl);
    checkOutput("bubble_cnt", bubble_cnt, e.bub); checkOutput("retire_cnt", retire_cnt, e.ret);
    checkOutput("ctrl_err", ctrl_err, e.err);
  endtask

  // Fresh random stage inputs; called while the clock is low
  task automatic drive_random();
    f_predPC = {$urandom, $urandom}; f_stat = 3'($urandom_range(0, 4));
    f_icode = 4'($urandom); f_ifun = 4'($urandom); f_rA = 4'($urandom); f_rB = 4'($urandom);
    f_valC = {$urandom, $urandom}; f_valP = {$urandom, $urandom};
    d_stat = 3'($urandom_range(0, 4)); d_icode = 4'($urandom); d_ifun = 4'($urandom);
    d_valC = {$urandom, $urandom}; d_valA = {$urandom, $urandom}; d_valB = {$urandom, $urandom};
    d_dstE = 4'($urandom); d_dstM = 4'($urandom); d_srcA = 4'($urandom); d_srcB = 4'($urandom);
    e_stat = 3'($urandom_range(0, 4)); e_icode = 4'($urandom); e_Cnd = 1'($urandom);
    e_valE = {$urandom, $urandom}; e_valA = {$urandom, $urandom};
    e_dstE = 4'($urandom); e_dstM = 4'($urandom);
    m_stat = ($urandom_range(0, 2) != 0) ? 3'd1 : 3'($urandom_range(2, 4));
    m_icode = 4'($urandom_range(0, 11));
    m_valE = {$urandom, $urandom}; m_valM = {$urandom, $urandom};
    m_dstE = 4'($urandom); m_dstM = 4'($urandom);
  endtask

  // Apply controls, advance the model, push the expectation, clock once, pop and compare
  task automatic applyStimulus(input logic [5:0] ctl);
    exp_t n;
    exp_t got;
    {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall} = ctl;
    n = mdl;
    if (!F_stall) n.F_predPC = f_predPC;
    if (!D_stall) begin
      if (D_bubble) begin
        n.D_stat = 3'd1; n.D_icode = 4'd1; n.D_ifun = 4'd0; n.D_rA = 4'hF; n.D_rB = 4'hF;
        n.D_valC = '0; n.D_valP = '0;
      end else begin
        n.D_stat = f_stat; n.D_icode = f_icode; n.D_ifun = f_ifun; n.D_rA = f_rA; n.D_rB = f_rB;
        n.D_valC = f_valC; n.D_valP = f_valP;
      end
    end
    if (E_bubble) begin
      n.E_stat = 3'd1; n.E_icode = 4'd1; n.E_ifun = 4'd0; n.E_valC = '0; n.E_valA = '0; n.E_valB = '0;
      n.E_dstE = 4'hF; n.E_dstM = 4'hF; n.E_srcA = 4'hF; n.E_srcB = 4'hF;
    end else begin
      n.E_stat = d_stat; n.E_icode = d_icode; n.E_ifun = d_ifun; n.E_valC = d_valC;
      n.E_valA = d_valA; n.E_valB = d_valB; n.E_dstE = d_dstE; n.E_dstM = d_dstM;
      n.E_srcA = d_srcA; n.E_srcB = d_srcB;
    end
    if (M_bubble) begin
      n.M_stat = 3'd1; n.M_icode = 4'd1; n.M_Cnd = 1'b0; n.M_valE = '0; n.M_valA = '0;
      n.M_dstE = 4'hF; n.M_dstM = 4'hF;
    end else begin
      n.M_stat = e_stat; n.M_icode = e_icode; n.M_Cnd = e_Cnd; n.M_valE = e_valE;
      n.M_valA = e_valA; n.M_dstE = e_dstE; n.M_dstM = e_dstM;
    end
    if (!W_stall) begin
      n.W_stat = m_stat; n.W_icode = m_icode; n.W_valE = m_valE; n.W_valM = m_valM;
      n.W_dstE = m_dstE; n.W_dstM = m_dstM;
    end
    n.cyc = sat(mdl.cyc);
    if (F_stall) n.stl = sat(mdl.stl);
    if (D_bubble || E_bubble || M_bubble) n.bub = sat(mdl.bub);
    if (!W_stall && mdl.W_stat == 3'd1 && mdl.W_icode != 4'd1) n.ret = sat(mdl.ret);
    if (D_stall && D_bubble) n.err = 1'b1;
    mdl = n;
    sb.push_back(n);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checkOutput("sb_underflow", 64'd0, 64'd1);
    end else begin
      got = sb.pop_front();
      compareState(got);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] held_icode;
    logic [CW-1:0] ret_saved;

    rst_n = 1'b0;
    {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall} = '0;
    drive_random();
    mdl = nop_state();

    // Reset values while rst_n is low and clock edges pass
    @(negedge clk);
    @(negedge clk);
    compareState(nop_state());
    rst_n = 1'b1;

    // Three free-running cycles; keep W fed with NOPs so nothing retires
    for (int i = 0; i < 3; i++) begin
      drive_random();
      f_predPC = 64'h10 + 64'(10 * i);
      f_icode = (i == 2) ? 4'd6 : 4'd2;
      m_stat = 3'd1; m_icode = 4'd1;
      applyStimulus(6'b000000);
    end
    checkOutput("free_predPC", F_predPC, 64'h24);
    checkOutput("free_D_icode", D_icode, 64'd6);
    checkOutput("free_cycle", cycle_cnt, 64'd3);
    checkOutput("free_stall", stall_cnt, 64'd0);
    checkOutput("free_bubble", bubble_cnt, 64'd0);
    checkOutput("free_retire", retire_cnt, 64'd0);

    // Load-use: F and D hold, E takes a bubble
    drive_random();
    applyStimulus(6'b110100);
    checkOutput("lu_predPC", F_predPC, 64'h24);
    checkOutput("lu_D_icode", D_icode, 64'd6);
    checkOutput("lu_E_icode", E_icode, 64'd1);
    checkOutput("lu_E_dstE", E_dstE, 64'hF);
    checkOutput("lu_stall", stall_cnt, 64'd1);
    checkOutput("lu_bubble", bubble_cnt, 64'd1);

    // Mispredict: D and E bubble together count once
    drive_random();
    applyStimulus(6'b001100);
    checkOutput("mp_D_icode", D_icode, 64'd1);
    checkOutput("mp_D_rA", D_rA, 64'hF);
    checkOutput("mp_E_icode", E_icode, 64'd1);
    checkOutput("mp_bubble", bubble_cnt, 64'd2);

    // Exception: load a faulting status into W, then hold W with M bubbled
    drive_random();
    m_stat = 3'd2;
    applyStimulus(6'b000000);
    checkOutput("ex_W_stat_load", W_stat, 64'd2);
    ret_saved = mdl.ret;
    for (int i = 0; i < 4; i++) begin
      drive_random();
      applyStimulus(6'b000011);
      checkOutput("ex_W_stat_hold", W_stat, 64'd2);
      checkOutput("ex_M_icode", M_icode, 64'd1);
      checkOutput("ex_retire", retire_cnt, 64'(ret_saved));
    end

    // Contradictory D controls: hold wins and the error flag sticks
    drive_random();
    held_icode = mdl.D_icode;
    applyStimulus(6'b011000);
    checkOutput("ce_D_hold", D_icode, 64'(held_icode));
    checkOutput("ce_err_set", ctrl_err, 64'd1);
    for (int i = 0; i < 3; i++) begin
      drive_random();
      applyStimulus(6'b000000);
      checkOutput("ce_err_sticky", ctrl_err, 64'd1);
    end

    // Random traffic long enough to saturate the narrow counters
    for (int i = 0; i < 40; i++) begin
      drive_random();
      applyStimulus({($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                     ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)});
    end
    checkOutput("sat_cycle", cycle_cnt, 64'd15);

    // Asynchronous reset in the middle of a low clock phase
    #2;
    rst_n = 1'b0;
    #1;
    compareState(nop_state());
    mdl = nop_state();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      drive_random();
      applyStimulus({($urandom_range(0, 3) == 0), 1'b0, ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 3) == 0)});
    end
    checkOutput("post_rst_cycle", cycle_cnt, 64'd10);
    checkOutput("post_rst_err", ctrl_err, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
